aes_128_job_arbiter: RTL and testbench

Shares one AES-128 encryption core between two block requesters, for example the AXI4-Lite register front-end and a DMA/stream path.
- Arbitrates between them round-robin, captures the winner's key, plaintext and tag, and sequences the core through start/done.
- Returns the ciphertext, tag and error flag to the requester that issued the job.
- Sits between the AXI slave logic of the encryption IP and the AES round core; one job is in flight at a time.

---
 rtl/aes_128_job_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_aes_128_job_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_job_arbiter.sv
// aes_128_job_arbiter
//   Shares one AES-128 core between two block requesters. Round-robin
//   arbitration, capture of the winning key/plaintext/tag, start/done
//   sequencing of the core, and return of ciphertext/tag/error to the
//   requester that issued the job. One job in flight at a time.
//
// Optional feature macro: AES_ARB_TIMEOUT_EN
//   Defined   : a 16-bit WAIT counter aborts the job after TIMEOUT_CYCLES
//               cycles without core_done (ct=0, err=1).
//   Undefined : no counter, rspN_err tied low, WAIT lasts until core_done.
//
// Parameters
//   TAG_W          width of the opaque request tag echoed on the response
//   TIMEOUT_CYCLES WAIT cycle limit (2..65535), timeout build only
//
// Ports
//   ACLK, ARESETN              clock, async active-low reset
//   reqN_valid/ready           request handshake (N = 0,1)
//   reqN_key/pt/tag            job payload
//   rspN_valid/ready           response handshake
//   rspN_ct/tag/err            response payload
//   core_start/key/pt          job issue to the AES core
//   core_done/ct               completion from the AES core
//   busy                       high in every state except IDLE
`timescale 1ns/1ps

module aes_128_job_arbiter #(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [127:0]     req0_key,
  input  logic [127:0]     req0_pt,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [127:0]     req1_key,
  input  logic [127:0]     req1_pt,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [127:0]     rsp0_ct,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [127:0]     rsp1_ct,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             rsp1_err,
  output logic             core_start,
  output logic [127:0]     core_key,
  output logic [127:0]     core_pt,
  input  logic             core_done,
  input  logic [127:0]     core_ct,
  output logic             busy
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_next;

  logic              sel;         // arbitration winner in IDLE
  logic              grant;       // owner of the job in flight
  logic              last_grant;  // owner of the last completed job
  logic              req_hs;
  logic              rsp_hs;
  logic              timeout_hit;

  logic [127:0]      key_q;
  logic [127:0]      pt_q;
  logic [TAG_W-1:0]  tag_q;
  logic [127:0]      ct_q;

  logic              start_q;
  logic              busy_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;

  assign req_hs = (state == S_IDLE) && (req0_valid || req1_valid);
  assign rsp_hs = (state == S_RESP) && (grant ? rsp1_ready : rsp0_ready);

`ifdef AES_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        err_q;

  // Cleared while in ISSUE so it reads 0 in the first WAIT cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_q <= 1'b0;
    end else if (state == S_WAIT) begin
      if (core_done) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp0_err = err_q;
  assign rsp1_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp0_err    = 1'b0;
  assign rsp1_err    = 1'b0;
`endif

  // State register; start/busy/valid are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state        <= state_next;
      start_q      <= (state_next == S_ISSUE);
      busy_q       <= (state_next != S_IDLE);
      rsp0_valid_q <= (state_next == S_RESP) && !grant;
      rsp1_valid_q <= (state_next == S_RESP) && grant;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (req_hs) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (core_done || timeout_hit) state_next = S_RESP;
      S_RESP:  if (rsp_hs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Only one ready can be high: the sole valid requester, or the one not
  // granted last when both are valid.
  always_comb begin
    sel        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = (state == S_IDLE) && req0_valid && !sel;
    req1_ready = (state == S_IDLE) && req1_valid && sel;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;  // req0 wins the first contended round
      key_q      <= '0;
      pt_q       <= '0;
      tag_q      <= '0;
      ct_q       <= '0;
    end else begin
      if (req_hs) begin
        grant <= sel;
        key_q <= sel ? req1_key : req0_key;
        pt_q  <= sel ? req1_pt  : req0_pt;
        tag_q <= sel ? req1_tag : req0_tag;
      end
      if (state == S_WAIT) begin
        if (core_done) begin
          ct_q <= core_ct;
        end else if (timeout_hit) begin
          ct_q <= '0;
        end
      end
      if (rsp_hs) begin
        last_grant <= grant;
      end
    end
  end

  assign core_start = start_q;
  assign core_key   = key_q;
  assign core_pt    = pt_q;
  assign busy       = busy_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_ct    = ct_q;
  assign rsp1_ct    = ct_q;
  assign rsp0_tag   = tag_q;
  assign rsp1_tag   = tag_q;

endmodule

// File: tb/tb_aes_128_job_arbiter.sv
// Directed bench for aes_128_job_arbiter with a behavioural AES core stub.
// The stub returns the FIPS-197 ciphertext for the FIPS-197 key/plaintext and
// a fixed XOR mix of key and plaintext for every other job.
`timescale 1ns/1ps

module tb_aes_128_job_arbiter;

  localparam int unsigned TAG_W = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIX      = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic             ACLK = 1'b0;
  logic             ARESETN;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0]     req0_key, req0_pt, req1_key, req1_pt;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp0_valid, rsp0_ready, rsp0_err;
  logic             rsp1_valid, rsp1_ready, rsp1_err;
  logic [127:0]     rsp0_ct, rsp1_ct;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
  logic             core_start, core_done, busy;
  logic [127:0]     core_key, core_pt, core_ct;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 ACLK = ~ACLK;

  aes_128_job_arbiter #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key),
    .req0_pt(req0_pt), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key),
    .req1_pt(req1_pt), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_ct(rsp0_ct),
    .rsp0_tag(rsp0_tag), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_ct(rsp1_ct),
    .rsp1_tag(rsp1_tag), .rsp1_err(rsp1_err),
    .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
    .core_done(core_done), .core_ct(core_ct), .busy(busy)
  );

  // ---------------- behavioural core ----------------
  int           core_lat;
  bit           core_mute;
  int           mcnt;
  logic         model_done;
  logic [127:0] model_ct;
  logic         extra_done;
  logic [127:0] extra_ct;

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ p ^ MIX;
  endfunction

  // core_lat = N puts done in the N-th WAIT cycle.
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      model_done <= 1'b0;
      model_ct   <= '0;
      mcnt       <= 0;
    end else if (core_start) begin
      model_ct   <= core_fn(core_key, core_pt);
      model_done <= !core_mute && (core_lat == 1);
      mcnt       <= core_lat - 1;
    end else if (mcnt > 0) begin
      mcnt       <= mcnt - 1;
      model_done <= !core_mute && (mcnt == 1);
    end else begin
      model_done <= 1'b0;
    end
  end

  assign core_done = model_done | extra_done;
  assign core_ct   = extra_done ? extra_ct : model_ct;

  bit rsp1_seen;
  always @(negedge ACLK) if (rsp1_valid) rsp1_seen = 1'b1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  // Offer a job and hold it until accepted; returns in the ISSUE cycle.
  task automatic offer(input int n, input logic [127:0] k, input logic [127:0] p,
                       input logic [TAG_W-1:0] t);
    int w = 0;
    if (n == 0) begin
      req0_key = k; req0_pt = p; req0_tag = t; req0_valid = 1'b1;
    end else begin
      req1_key = k; req1_pt = p; req1_tag = t; req1_valid = 1'b1;
    end
    #1;
    while (!(n == 0 ? req0_ready : req1_ready) && w < 50) begin
      cyc(); #1; w++;
    end
    chk("offer_ready", 128'(n == 0 ? req0_ready : req1_ready), 128'd1);
    cyc();
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_valid(input int n, input int max);
    int w = 0;
    #1;
    while (!(n == 0 ? rsp0_valid : rsp1_valid) && w < max) begin
      cyc(); #1; w++;
    end
  endtask

  task automatic finish_rsp(input int n);
    if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input int n, input logic [127:0] ct,
                            input logic [TAG_W-1:0] tag, input logic err);
    wait_valid(n, 40);
    if (n == 0) begin
      chk({name, "_valid"}, 128'(rsp0_valid), 128'd1);
      chk({name, "_ct"},    rsp0_ct, ct);
      chk({name, "_tag"},   128'(rsp0_tag), 128'(tag));
      chk({name, "_err"},   128'(rsp0_err), 128'(err));
    end else begin
      chk({name, "_valid"}, 128'(rsp1_valid), 128'd1);
      chk({name, "_ct"},    rsp1_ct, ct);
      chk({name, "_tag"},   128'(rsp1_tag), 128'(tag));
      chk({name, "_err"},   128'(rsp1_err), 128'(err));
    end
    finish_rsp(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] KA = 128'h11111111222222223333333344444444;
  localparam logic [127:0] PA = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] KB = 128'hdeadbeefcafef00d0badc0de12345678;
  localparam logic [127:0] PB = 128'h00000000000000000000000000000001;
  localparam logic [127:0] KC = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
  localparam logic [127:0] PC = 128'hffffffff00000000ffffffff00000000;
  localparam logic [127:0] XCT = 128'hc0ffee00c0ffee00c0ffee00c0ffee00;

  initial begin
    ARESETN = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_key = '0; req0_pt = '0; req0_tag = '0;
    req1_key = '0; req1_pt = '0; req1_tag = '0;
    core_lat = 2; core_mute = 0; extra_done = 0; extra_ct = '0;
    rsp1_seen = 0;

    // Reset values
    repeat (3) cyc();
    #1;
    chk("rst_busy",       128'(busy), 128'd0);
    chk("rst_core_start", 128'(core_start), 128'd0);
    chk("rst_rsp0_valid", 128'(rsp0_valid), 128'd0);
    chk("rst_rsp1_valid", 128'(rsp1_valid), 128'd0);
    chk("rst_core_key",   core_key, 128'd0);
    chk("rst_rsp0_err",   128'(rsp0_err), 128'd0);
    ARESETN = 1'b1;
    cyc();

    // Round-robin: simultaneous pair after reset -> req0 first
    req0_key = KA; req0_pt = PA; req0_tag = 4'h1; req0_valid = 1;
    req1_key = KB; req1_pt = PB; req1_tag = 4'h2; req1_valid = 1;
    #1;
    chk("rr1_ready0", 128'(req0_ready), 128'd1);
    chk("rr1_ready1", 128'(req1_ready), 128'd0);
    cyc();
    req0_valid = 0;
    #1;
    chk("rr1_issue_start", 128'(core_start), 128'd1);
    chk("rr1_core_key",    core_key, KA);
    chk("rr1_core_pt",     core_pt, PA);
    chk("rr1_ready1_busy", 128'(req1_ready), 128'd0);
    expect_rsp("rr1_rsp0", 0, core_fn(KA, PA), 4'h1, 1'b0);
    // Second pair: req0 re-offers while req1 still pending -> req1 first,
    // accepted in the cycle right after the response handshake.
    req0_key = KC; req0_pt = PC; req0_tag = 4'h3; req0_valid = 1;
    #1;
    chk("rr2_ready1", 128'(req1_ready), 128'd1);
    chk("rr2_ready0", 128'(req0_ready), 128'd0);
    cyc();
    req1_valid = 0;
    expect_rsp("rr2_rsp1", 1, core_fn(KB, PB), 4'h2, 1'b0);
    #1;
    chk("rr3_ready0", 128'(req0_ready), 128'd1);
    cyc();
    req0_valid = 0;
    expect_rsp("rr3_rsp0", 0, core_fn(KC, PC), 4'h3, 1'b0);

    // FIPS-197 vector on req0
    core_lat = 3;
    rsp1_seen = 0;
    offer(0, FIPS_KEY, FIPS_PT, 4'h5);
    expect_rsp("fips", 0, FIPS_CT, 4'h5, 1'b0);
    chk("fips_rsp1_quiet", 128'(rsp1_seen), 128'd0);

    // Minimum latency: done in first WAIT cycle -> rsp_valid at k+3
    core_lat = 1;
    req1_key = KB; req1_pt = PA; req1_tag = 4'h7; req1_valid = 1;
    #1;
    cyc();              // cycle k+1, ISSUE
    req1_valid = 0;
    #1;
    chk("lat_start", 128'(core_start), 128'd1);
    cyc();              // cycle k+2, WAIT
    #1;
    chk("lat_start_off", 128'(core_start), 128'd0);
    chk("lat_k2_valid",  128'(rsp1_valid), 128'd0);
    cyc();              // cycle k+3, RESP
    #1;
    chk("lat_k3_valid", 128'(rsp1_valid), 128'd1);
    chk("lat_k3_ct",    rsp1_ct, core_fn(KB, PA));
    finish_rsp(1);
    #1;
    chk("lat_idle_busy", 128'(busy), 128'd0);

    // Backpressure on rsp0 for 10 cycles with req1 waiting
    core_lat = 2;
    offer(0, KC, PB, 4'h9);
    wait_valid(0, 40);
    req1_key = KA; req1_pt = PC; req1_tag = 4'hc; req1_valid = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_valid",  128'(rsp0_valid), 128'd1);
      chk("bp_ct",     rsp0_ct, core_fn(KC, PB));
      chk("bp_tag",    128'(rsp0_tag), 128'h9);
      chk("bp_ready1", 128'(req1_ready), 128'd0);
      chk("bp_busy",   128'(busy), 128'd1);
      cyc();
    end
    rsp0_ready = 1;
    cyc();
    rsp0_ready = 0;
    #1;
    chk("bp_rel_valid",  128'(rsp0_valid), 128'd0);
    chk("bp_rel_busy",   128'(busy), 128'd0);
    chk("bp_rel_ready1", 128'(req1_ready), 128'd1);
    cyc();
    req1_valid = 0;
    expect_rsp("bp_rsp1", 1, core_fn(KA, PC), 4'hc, 1'b0);

    // Reset mid-WAIT
    core_mute = 1;
    offer(0, KB, PB, 4'ha);
    cyc();
    cyc();
    ARESETN = 0;
    #1;
    chk("mrst_busy",     128'(busy), 128'd0);
    chk("mrst_start",    128'(core_start), 128'd0);
    chk("mrst_core_key", core_key, 128'd0);
    chk("mrst_core_pt",  core_pt, 128'd0);
    chk("mrst_valid0",   128'(rsp0_valid), 128'd0);
    chk("mrst_ct0",      rsp0_ct, 128'd0);
    chk("mrst_tag0",     128'(rsp0_tag), 128'd0);
    cyc();
    ARESETN = 1;
    core_mute = 0;
    cyc();
    extra_ct = XCT; extra_done = 1;
    cyc();
    extra_done = 0;
    #1;
    chk("stale_busy",   128'(busy), 128'd0);
    chk("stale_valid0", 128'(rsp0_valid), 128'd0);
    chk("stale_valid1", 128'(rsp1_valid), 128'd0);
    offer(1, KC, PA, 4'h3);
    expect_rsp("post_rst", 1, core_fn(KC, PA), 4'h3, 1'b0);

`ifdef AES_ARB_TIMEOUT_EN
    // Timeout: WAIT from k+2, 8 counted cycles, rsp_valid at k+11
    core_mute = 1;
    offer(0, KA, PB, 4'h6);                 // cycle k+1
    repeat (9) cyc();                       // cycle k+10
    #1;
    chk("to_early", 128'(rsp0_valid), 128'd0);
    cyc();                                  // cycle k+11
    #1;
    chk("to_valid", 128'(rsp0_valid), 128'd1);
    chk("to_ct",    rsp0_ct, 128'd0);
    chk("to_err",   128'(rsp0_err), 128'd1);
    chk("to_tag",   128'(rsp0_tag), 128'h6);
    finish_rsp(0);

    // done coincides with expiry: done wins
    offer(1, KB, PC, 4'h2);                 // cycle k+1
    repeat (9) cyc();                       // cycle k+10, expiry
    extra_ct = XCT; extra_done = 1;
    cyc();
    extra_done = 0;
    #1;
    chk("co_valid", 128'(rsp1_valid), 128'd1);
    chk("co_ct",    rsp1_ct, XCT);
    chk("co_err",   128'(rsp1_err), 128'd0);
    finish_rsp(1);
    core_mute = 0;
`else
    // No timeout: a silent core keeps the arbiter busy indefinitely
    core_mute = 1;
    offer(0, KA, PB, 4'h6);
    repeat (1100) cyc();
    #1;
    chk("nto_busy",  128'(busy), 128'd1);
    chk("nto_valid", 128'(rsp0_valid), 128'd0);
    ARESETN = 0;
    cyc();
    ARESETN = 1;
    core_mute = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
